cache_wb_reader: RTL
====================

Name: cache_wb_reader

Overview:
- Write-back reader for the SDRAM cache data RAM: reads one dirty cache line from a byte-enabled dual-port RAM read port and streams it to the SDRAM controller as a 16-bit write burst with per-byte masks.
- Sits between the cache data RAM (one port dedicated to it) and the SDRAM controller write channel.
- Handles the RAM's 1-cycle registered read latency by prefetching the next 32-bit word while the current one drains as two 16-bit beats.

Parameters:
- ADDR_W, 10, RAM word address width (32-bit words).
- LINE_W, 2, log2 of 32-bit words per cache line (default 4 words = 8 beats).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to write back a line; accepted only in IDLE.
- line_idx  in  ADDR_W-LINE_W  line number; base word address = line_idx << LINE_W.
- dirty_mask  in  4<<LINE_W  byte-dirty mask; bit 4n+k = byte k (bits 8k+7:8k) of word n.
- busy  out  1  high while a write-back is in progress.
- done  out  1  one-cycle pulse when the write-back completes.
- ram_addr  out  ADDR_W  registered read address to RAM port.
- ram_q  in  32  RAM read data; valid one clock after ram_addr is presented.
- wb_req  out  1  beat valid toward SDRAM controller.
- wb_ack  in  1  controller accepts the current beat on a rising edge where wb_req=1.
- wb_data  out  16  beat data.
- wb_dqm  out  2  byte mask, active high = byte NOT written; [1] for wb_data[15:8].
- wb_last  out  1  high with the final beat of the line.

Behaviour:
- Reset (async, reset_n=0): state IDLE. busy, done, wb_req, wb_last and wb_dqm are 0. wb_data and ram_addr are 0. All internal registers are cleared.
- Reset mid-burst aborts immediately: wb_req drops asynchronously. No done pulse is generated.
- States:
  - IDLE: on start, latch line_idx and dirty_mask, set ram_addr=base, busy=1.
    - If the latched mask is all zero, go to FIN.
    - Otherwise go to FETCH.
    - start while not IDLE is ignored.
  - FETCH: one cycle. Load word buffer from ram_q (word 0), set ram_addr=base+1, go to HI.
  - HI: wb_req=1, wb_data=buf[31:16], wb_dqm=~mask[4n+3:4n+2]. On wb_ack, go to LO.
  - LO: wb_req=1, wb_data=buf[15:0], wb_dqm=~mask[4n+1:4n]. wb_last=1 when n is the last word.
    - On wb_ack with more words left: load buffer from ram_q (word n+1), set ram_addr to word n+2 (not incremented past the line end), n++, go to HI.
    - On wb_ack with the last word: go to FIN.
  - FIN: busy=0 and done=1 for exactly one cycle, then IDLE.
- Beat order is big-endian: the upper half of each word goes first, at the lower SDRAM address.
- Outputs hold stable while wb_req=1 and wb_ack=0. wb_req stays high between beats with no bubbles; back-to-back acks give one beat per cycle.
- Timing:
  - Start accepted at edge E0 gives first wb_req after E1.
  - Minimum line time is 2 + 2·2^LINE_W cycles from start to done.
  - A zero-mask line gives done 1 cycle after start, with no wb_req.
- Prefetch correctness: ram_addr changes at the edge where the buffer loads word n. ram_q holds word n+1 from the following edge, at least one edge before the earliest LO ack.
- The line's RAM contents must not be written through the other port while busy=1. This is guaranteed by the cache controller and is not checked here.
- Beats whose wb_dqm=2'b11 are still sent, so the burst length is fixed.
- Counter n is LINE_W bits wide and does not wrap within a line. ram_addr stays inside the line (base .. base+2^LINE_W-1).

Test Plan:
- Full-dirty line: RAM words 0..3 = 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; line_idx=5; mask=0xFFFF; wb_ack held 1.
  - Required beats: 0x1122, 0x3344, 0x5566, 0x7788, 0x99AA, 0xBBCC, 0xDDEE, 0xFF00.
  - dqm=00 throughout. wb_last only on beat 8.
  - ram_addr sequence 20, 21, 22, 23.
  - done pulse 10 cycles after start.
- Partial mask 0x000C (word 0, bytes 2–3 only) -> beat0 dqm=00; all other beats dqm=11. Still 8 beats.
- Zero mask -> no wb_req. done exactly 1 cycle after start; busy high 1 cycle.
- Backpressure: wb_ack random 30% duty -> wb_data, wb_dqm and wb_last stable while waiting. Beat sequence identical to test 1.
- start asserted during busy with a different line_idx -> ignored. The original line completes unchanged.
- reset_n low during beat 3 -> wb_req, busy and done go 0 immediately. A new start after release performs a full line normally.

Source files
------------

// File: rtl/cache_wb_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_wb_reader_if
//  Description : RAM read port and SDRAM write-burst channel of the
//                cache write-back reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_wb_reader_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_q;
    logic              wb_req;
    logic              wb_ack;
    logic [15:0]       wb_data;
    logic [1:0]        wb_dqm;
    logic              wb_last;

    modport master (
        output ram_addr, wb_req, wb_data, wb_dqm, wb_last,
        input  ram_q, wb_ack
    );

    modport slave (
        input  ram_addr, wb_req, wb_data, wb_dqm, wb_last,
        output ram_q, wb_ack
    );
endinterface
`default_nettype wire

// File: rtl/cache_wb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cache_wb_reader
//  Description : Reads one dirty cache line from the data RAM and streams it
//                to the SDRAM controller as a masked 16-bit write burst.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_wb_reader #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-LINE_W-1:0] line_idx,
    input  logic [(4<<LINE_W)-1:0]   dirty_mask,
    output logic                     busy,
    output logic                     done,
    cache_wb_reader_if.master        bus
);

    localparam int IDX_W = ADDR_W - LINE_W;
    localparam int MSK_W = 4 << LINE_W;
    localparam logic [LINE_W-1:0] c_LAST  = '1;
    localparam logic [LINE_W-1:0] c_WORD1 = LINE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_base,  w_base_nxt;
    logic [MSK_W-1:0]    r_mask,  w_mask_nxt;
    logic [31:0]         r_buf,   w_buf_nxt;
    logic [LINE_W-1:0]   r_n,     w_n_nxt;
    logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic                r_busy,  w_busy_nxt;
    logic                r_done,  w_done_nxt;

    logic [LINE_W-1:0]   w_n_p1, w_n_p2;
    logic [3:0]          w_word_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_mask  <= '0;
            r_buf   <= '0;
            r_n     <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_mask  <= w_mask_nxt;
            r_buf   <= w_buf_nxt;
            r_n     <= w_n_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_n_p1 = r_n + 1'b1;
    assign w_n_p2 = w_n_p1 + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_mask_nxt  = r_mask;
        w_buf_nxt   = r_buf;
        w_n_nxt     = r_n;
        w_addr_nxt  = r_addr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_nxt  = line_idx;
                    w_mask_nxt  = dirty_mask;
                    w_addr_nxt  = {line_idx, {LINE_W{1'b0}}};
                    w_n_nxt     = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (dirty_mask == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                // Word 0 arrives now; point the RAM at word 1 so it is ready
                // before the first LO beat can be acknowledged.
                w_buf_nxt   = bus.ram_q;
                w_addr_nxt  = {r_base, c_WORD1};
                w_state_nxt = S_HI;
            end
            S_HI: begin
                if (bus.wb_ack) begin
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (bus.wb_ack) begin
                    if (r_n == c_LAST) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_buf_nxt   = bus.ram_q;
                        w_n_nxt     = w_n_p1;
                        // Prefetch pointer stops at the final word of the line.
                        w_addr_nxt  = {r_base, (w_n_p1 == c_LAST) ? c_LAST : w_n_p2};
                        w_state_nxt = S_HI;
                    end
                end
            end
            S_FIN: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_n_nxt     = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Beat outputs decode straight from registered state, so they hold while
    // waiting for an ack and collapse the instant reset is asserted.
    assign w_word_mask = r_mask[{r_n, 2'b00} +: 4];

    always_comb begin
        bus.wb_req  = 1'b0;
        bus.wb_data = '0;
        bus.wb_dqm  = '0;
        bus.wb_last = 1'b0;
        if (r_state == S_HI) begin
            bus.wb_req  = 1'b1;
            bus.wb_data = r_buf[31:16];
            bus.wb_dqm  = ~w_word_mask[3:2];
        end else if (r_state == S_LO) begin
            bus.wb_req  = 1'b1;
            bus.wb_data = r_buf[15:0];
            bus.wb_dqm  = ~w_word_mask[1:0];
            bus.wb_last = (r_n == c_LAST);
        end
    end

    assign bus.ram_addr = r_addr;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire
